// File: rtl/exc_arbiter_pkg.sv
// Exception codes and arbiter state encoding shared by the exception arbiter and CP0.
// Also holds the fixed-priority ExcCode selection for synchronous exceptions.
package exc_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } exc_state_t;

  // syscall > break > trap; the caller guarantees at least one is active
  function automatic logic [4:0] sync_code(input logic syscall, input logic brk);
    if (syscall)  return EXC_SYS;
    else if (brk) return EXC_BP;
    else          return EXC_TR;
  endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// Decode/CP0-side bundle into the exception arbiter; master drives decode and CP0 state,
// slave (the arbiter) returns the exception request and handler status.
interface exc_arbiter_if #(
  parameter int N_IRQ = 3,
  parameter int CNT_W = 32
);
  logic             syscall;
  logic             brk;
  logic             teq;
  logic             teq_cond;
  logic             eret;
  logic [N_IRQ-1:0] irq;
  logic             status_ie;
  logic [N_IRQ:0]   status_im;
  logic [31:0]      pc;
  logic             timer_wr;
  logic [CNT_W-1:0] timer_wdata;

  logic             exc_req;
  logic [4:0]       exc_code;
  logic [31:0]      exc_pc;
  logic [31:0]      exc_vec;
  logic [2:0]       irq_id;
  logic             in_service;
  logic             double_fault;
  logic             timer_irq;

  modport master (
    output syscall, brk, teq, teq_cond, eret, irq, status_ie, status_im, pc,
           timer_wr, timer_wdata,
    input  exc_req, exc_code, exc_pc, exc_vec, irq_id, in_service, double_fault, timer_irq
  );

  modport slave (
    input  syscall, brk, teq, teq_cond, eret, irq, status_ie, status_im, pc,
           timer_wr, timer_wdata,
    output exc_req, exc_code, exc_pc, exc_vec, irq_id, in_service, double_fault, timer_irq
  );
endinterface

// File: rtl/exc_arbiter_irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line plus a rising-edge pulse.
// Pulse is high for one cycle, two edges after the line rises.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta, sync, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign pulse = sync & ~sync_q;

endmodule

// File: rtl/exc_arbiter.sv
// Prioritises sync exceptions and interrupts into one CP0 exception request per handler entry.
// Optional compare timer on interrupt index N_IRQ when TIMER_IRQ_EN is defined.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int          N_IRQ      = 3,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter int          CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  exc_arbiter_if.slave  bus
);

  exc_state_t       state;
  logic             in_service_q;
  logic             double_fault_q;
  logic [N_IRQ-1:0] irq_pulse;
  logic [N_IRQ:0]   pending, pending_nxt, edge_set, im_eff, take_mask, clr_mask;
  logic             timer_hit, timer_clr;
  logic             sync_any, win_any, req, int_take;
  logic [2:0]       win_id;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.irq[g]),
      .pulse (irq_pulse[g])
    );
  end

`ifdef TIMER_IRQ_EN
  logic [CNT_W-1:0] count, compare;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
    end else begin
      count <= count + CNT_W'(1);
      if (bus.timer_wr) compare <= bus.timer_wdata;
    end
  end

  assign timer_hit     = (count == compare) && (compare != '0);
  assign timer_clr     = bus.timer_wr;
  assign im_eff        = bus.status_im;
  assign bus.timer_irq = pending[N_IRQ];
`else
  logic unused_timer;
  assign unused_timer  = ^{bus.timer_wr, bus.timer_wdata, bus.status_im[N_IRQ]};
  assign timer_hit     = 1'b0;
  assign timer_clr     = 1'b0;
  assign im_eff        = {1'b0, bus.status_im[N_IRQ-1:0]};
  assign bus.timer_irq = 1'b0;
`endif

  assign edge_set  = {timer_hit, irq_pulse};
  assign take_mask = pending & im_eff & {(N_IRQ+1){bus.status_ie}};
  assign sync_any  = bus.syscall | bus.brk | (bus.teq & bus.teq_cond);

  // Descending scan so the lowest enabled index is the last one written
  always_comb begin
    win_id  = '0;
    win_any = 1'b0;
    for (int i = N_IRQ; i >= 0; i--) begin
      if (take_mask[i]) begin
        win_id  = 3'(i);
        win_any = 1'b1;
      end
    end
  end

  assign req      = (state == IDLE) && (sync_any || win_any);
  assign int_take = req && !sync_any;

  always_comb begin
    clr_mask = '0;
    if (int_take) clr_mask[win_id] = 1'b1;
    pending_nxt = (pending & ~clr_mask) | edge_set;
    if (timer_clr) pending_nxt[N_IRQ] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      in_service_q   <= 1'b0;
      double_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state        <= SERVICE;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          // Handler is not re-entrant: a sync exception here is unrecoverable
          if (sync_any) double_fault_q <= 1'b1;
          if (bus.eret) begin
            state        <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.exc_req      = req;
  assign bus.exc_code     = (req && sync_any) ? sync_code(bus.syscall, bus.brk) : EXC_INT;
  assign bus.exc_pc       = req ? bus.pc : 32'h0;
  assign bus.exc_vec      = EXC_VECTOR;
  assign bus.irq_id       = int_take ? win_id : 3'd0;
  assign bus.in_service   = in_service_q;
  assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Scenario bench for exc_arbiter: expected requests are queued at stimulus time and
// popped when the arbiter raises exc_req.
module tb_exc_arbiter;
  import exc_pkg::*;

  localparam int N_IRQ = 3;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic [2:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  exp_t exp_q[$];
  exp_t e;
  bit   got;

  exc_arbiter_if #(.N_IRQ(N_IRQ), .CNT_W(32)) bus ();

  exc_arbiter #(.N_IRQ(N_IRQ), .EXC_VECTOR(32'h0000_0004), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      seen = bus.exc_req;
    end
  endtask

  task automatic test_reset();
    bus.syscall = 0; bus.brk = 0; bus.teq = 0; bus.teq_cond = 0; bus.eret = 0;
    bus.irq = '0; bus.status_ie = 0; bus.status_im = '0; bus.pc = 32'h0;
    bus.timer_wr = 0; bus.timer_wdata = '0;
    step(); step();
    total++;
    if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id, bus.in_service, bus.double_fault, bus.timer_irq} !== 44'h0)
      $display("FAIL reset_outputs: got req=%0b code=%0d pc=%h id=%0d svc=%0b df=%0b tmr=%0b want all 0",
               bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id, bus.in_service, bus.double_fault, bus.timer_irq);
    else passed++;
    total++;
    if (bus.exc_vec !== 32'h0000_0004) $display("FAIL reset_vec: got %h want 00000004", bus.exc_vec);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_syscall();
    bus.pc = 32'h0040_0010; bus.syscall = 1;
    exp_q.push_back('{code: EXC_SYS, pc: 32'h0040_0010, id: 3'd0});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL syscall_req: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL syscall: got code=%0d pc=%h want code=%0d pc=%h", bus.exc_code, bus.exc_pc, e.code, e.pc);
      else passed++;
    end
    step(); bus.syscall = 0; #1;
    total++;
    if ({bus.in_service, bus.exc_req} !== 2'b10)
      $display("FAIL syscall_service: in_service=%0b exc_req=%0b want 1 0", bus.in_service, bus.exc_req);
    else passed++;
    bus.eret = 1; step(); bus.eret = 0; #1;
    total++;
    if (bus.in_service !== 1'b0) $display("FAIL eret_idle: in_service=%0b want 0", bus.in_service);
    else passed++;
  endtask

  task automatic test_sync_priority();
    bus.pc = 32'h0040_0020; bus.teq = 1; bus.teq_cond = 0; #1;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL teq_nocond: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    bus.teq_cond = 1;
    exp_q.push_back('{code: EXC_TR, pc: 32'h0040_0020, id: 3'd0});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL teq_req: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL teq_code: got code=%0d pc=%h want code=%0d pc=%h", bus.exc_code, bus.exc_pc, e.code, e.pc);
      else passed++;
    end
    step(); bus.teq = 0; bus.teq_cond = 0;
    bus.eret = 1; step(); bus.eret = 0;
    bus.pc = 32'h0040_0030; bus.syscall = 1; bus.brk = 1;
    exp_q.push_back('{code: EXC_SYS, pc: 32'h0040_0030, id: 3'd0});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL sys_brk_req: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL sys_brk_code: got code=%0d want code=%0d", bus.exc_code, e.code);
      else passed++;
    end
    step(); bus.syscall = 0; bus.brk = 0;
    bus.eret = 1; step(); bus.eret = 0;
    bus.pc = 32'h0040_0040; bus.brk = 1;
    exp_q.push_back('{code: EXC_BP, pc: 32'h0040_0040, id: 3'd0});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL brk_req: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL brk_code: got code=%0d want code=%0d", bus.exc_code, e.code);
      else passed++;
    end
    step(); bus.brk = 0;
    bus.eret = 1; step(); bus.eret = 0;
  endtask

  task automatic test_irq();
    bus.pc = 32'h0040_0100; bus.status_ie = 1; bus.status_im = 4'b0010;
    bus.irq[1] = 1;
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0100, id: 3'd1});
    step(); bus.irq[1] = 0;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL irq_edge1: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    step();
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL irq_edge2: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    step();
    total++;
    if (!bus.exc_req) $display("FAIL irq_edge3: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL irq1: got code=%0d id=%0d pc=%h want code=%0d id=%0d pc=%h",
                 bus.exc_code, bus.irq_id, bus.exc_pc, e.code, e.id, e.pc);
      else passed++;
    end
    step();
    bus.eret = 1; step(); bus.eret = 0; #1;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL irq_cleared: exc_req=%0b want 0", bus.exc_req);
    else passed++;

    bus.status_im = 4'b0000; bus.irq[1] = 1;
    step(); bus.irq[1] = 0;
    wait_req(5, got);
    total++;
    if (got) $display("FAIL irq_masked: exc_req=1 want 0");
    else passed++;
    bus.status_im = 4'b0010;
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0100, id: 3'd1});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL irq_unmask: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL irq_unmask_id: got code=%0d id=%0d want code=%0d id=%0d", bus.exc_code, bus.irq_id, e.code, e.id);
      else passed++;
    end
    step();
    bus.eret = 1; step(); bus.eret = 0;
  endtask

  task automatic test_irq_priority();
    bus.pc = 32'h0040_0200; bus.status_im = 4'b0111;
    bus.irq = 3'b101;
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0200, id: 3'd0});
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0200, id: 3'd2});
    step(); bus.irq = '0;
    wait_req(6, got);
    total++;
    if (!got) $display("FAIL prio_first: no request within budget");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL prio_first_id: got id=%0d want id=%0d", bus.irq_id, e.id);
      else passed++;
    end
    step(); bus.eret = 1; #1;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL prio_in_service: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    step(); bus.eret = 0; #1;
    total++;
    if (!bus.exc_req) $display("FAIL prio_second: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL prio_second_id: got id=%0d want id=%0d", bus.irq_id, e.id);
      else passed++;
    end
    step();
    bus.eret = 1; step(); bus.eret = 0; #1;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL prio_drained: exc_req=%0b want 0", bus.exc_req);
    else passed++;
  endtask

  task automatic test_service();
    bus.pc = 32'h0040_0500; bus.syscall = 1;
    exp_q.push_back('{code: EXC_SYS, pc: 32'h0040_0500, id: 3'd0});
    #1;
    total++;
    if (!bus.exc_req) $display("FAIL svc_entry: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL svc_entry_code: got code=%0d want code=%0d", bus.exc_code, e.code);
      else passed++;
    end
    step(); bus.syscall = 0;
    bus.irq[2] = 1; step(); bus.irq[2] = 0;
    step(); step(); step();
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL svc_irq_held: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    bus.brk = 1; #1;
    total++;
    if (bus.exc_req !== 1'b0) $display("FAIL svc_brk_req: exc_req=%0b want 0", bus.exc_req);
    else passed++;
    step(); bus.brk = 0; #1;
    total++;
    if (bus.double_fault !== 1'b1) $display("FAIL double_fault: got %0b want 1", bus.double_fault);
    else passed++;
    bus.eret = 1;
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0500, id: 3'd2});
    step(); bus.eret = 0; #1;
    total++;
    if (!bus.exc_req) $display("FAIL svc_accum: exc_req=0 want 1");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id} !== {1'b1, e})
        $display("FAIL svc_accum_id: got id=%0d want id=%0d", bus.irq_id, e.id);
      else passed++;
    end
    step();
    bus.irq[0] = 1; step(); bus.irq[0] = 0; step(); step();
    rst = 1; #1;
    total++;
    if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id, bus.in_service, bus.double_fault} !== 43'h0)
      $display("FAIL svc_reset: got req=%0b svc=%0b df=%0b pc=%h want all 0",
               bus.exc_req, bus.in_service, bus.double_fault, bus.exc_pc);
    else passed++;
    step(); rst = 0;
    wait_req(6, got);
    total++;
    if (got) $display("FAIL svc_pending_lost: exc_req=1 want 0");
    else passed++;
    bus.eret = 1; step(); bus.eret = 0; #1;
    total++;
    if ({bus.in_service, bus.exc_req} !== 2'b00)
      $display("FAIL eret_in_idle: in_service=%0b exc_req=%0b want 0 0", bus.in_service, bus.exc_req);
    else passed++;
  endtask

  task automatic test_timer();
    rst = 1; step(); rst = 0;
    bus.status_ie = 1; bus.status_im = 4'b1000; bus.pc = 32'h0040_0600;
    bus.timer_wr = 1; bus.timer_wdata = 32'd20;
    step(); bus.timer_wr = 0;
`ifdef TIMER_IRQ_EN
    exp_q.push_back('{code: EXC_INT, pc: 32'h0040_0600, id: 3'(N_IRQ)});
    wait_req(40, got);
    total++;
    if (!got) $display("FAIL timer_req: no request within budget");
    else begin
      e = exp_q.pop_front();
      if ({bus.exc_req, bus.exc_code, bus.exc_pc, bus.irq_id, bus.timer_irq} !== {1'b1, e, 1'b1})
        $display("FAIL timer_id: got id=%0d tmr=%0b want id=%0d tmr=1", bus.irq_id, bus.timer_irq, e.id);
      else passed++;
    end
    step(); bus.eret = 1; step(); bus.eret = 0;
`else
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      got = got | bus.timer_irq | bus.exc_req;
    end
    total++;
    if (got) $display("FAIL timer_disabled: timer_irq/exc_req seen=1 want 0");
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_sync_priority();
    test_irq();
    test_irq_priority();
    test_service();
    test_timer();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
